// File: rtl/alarm_scheduler.sv
// alarm_scheduler: Avalon-MM slave that derives a tick from clk with a
// prescaler and runs NUM_CH independent countdown alarm channels.
// Each channel counts whole ticks down from its load value, sets a sticky
// expired flag and contributes to a level irq when enabled.
// Optional build macro ALARM_SCHED_REPEAT_EN: CONTROL[7:4] become per-channel
// repeat enables (auto-reload on expiry). Without it all channels are one-shot.
//
// Bus handshake: a write is any cycle with chipselect && !write_n and takes
// effect at that clock edge; a read is any cycle with chipselect && write_n,
// and readdata shows the addressed register one cycle later (no wait states).
// Channel state is observable through the ARM register (active mask).
module alarm_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUNNING = 1'b1} state_t;

  logic              w_wr;
  logic              w_rd;
  logic [NUM_CH-1:0] w_arm;
  logic [NUM_CH-1:0] w_disarm;
  logic [NUM_CH-1:0] w_w1c;
  logic              w_tick;
  logic [3:0]        w_repeat;
  logic              w_unused_ok;

  logic [PRE_W-1:0]  r_presc;
  logic              r_run;
  logic [3:0]        r_irq_en;
  logic [1:0]        r_sel;
  logic [CNT_W-1:0]  r_load [NUM_CH];
  logic [CNT_W-1:0]  r_count [NUM_CH];
  logic [CNT_W-1:0]  w_count_nxt [NUM_CH];
  state_t            r_state [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_expired;
  logic [NUM_CH-1:0] w_exp_set;
  logic [NUM_CH-1:0] w_active;
  logic [15:0]       w_sel_load;
  logic [15:0]       w_sel_count;
  logic [15:0]       w_rd_mux;
  logic [15:0]       r_readdata;

  assign w_wr     = chipselect && !write_n;
  assign w_rd     = chipselect && write_n;
  assign w_arm    = (w_wr && address == 3'd5) ? writedata[NUM_CH-1:0] : '0;
  assign w_disarm = (w_wr && address == 3'd5) ? writedata[8 +: NUM_CH] : '0;
  assign w_w1c    = (w_wr && address == 3'd0) ? writedata[NUM_CH-1:0] : '0;
  assign w_tick   = r_run && (r_presc == PRE_MAX);

  // Not every writedata bit maps to a register for all parameter choices.
  assign w_unused_ok = ^{writedata, w_repeat};

`ifdef ALARM_SCHED_REPEAT_EN
  logic [3:0] r_repeat;
  // Repeat enables live in CONTROL[7:4].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_repeat <= '0;
    else if (w_wr && address == 3'd1) r_repeat <= writedata[7:4];
  end
  assign w_repeat = r_repeat;
`else
  assign w_repeat = 4'b0000;
`endif

  // Prescaler: free-runs 0..TICK_DIV-1 while run is set, parked at 0 otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_presc <= '0;
    else if (!r_run) r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRE_W'(1);
  end

  // CONTROL, SELECT and per-channel LOAD registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_irq_en <= '0;
      r_sel    <= '0;
      for (int i = 0; i < NUM_CH; i++) r_load[i] <= '0;
    end else if (w_wr) begin
      case (address)
        3'd1: begin
          r_run    <= writedata[15];
          r_irq_en <= writedata[3:0];
        end
        3'd2: r_sel <= writedata[1:0];
        3'd3: begin
          // A SELECT value beyond the last channel matches nothing: write dropped.
          for (int i = 0; i < NUM_CH; i++)
            if (r_sel == 2'(i)) r_load[i] <= writedata[CNT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Channel next-state: disarm beats arm, arm beats a tick, tick counts down.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_count_nxt[i] = r_count[i];
      w_exp_set[i]   = 1'b0;
      w_active[i]    = (r_state[i] == ST_RUNNING);
      if (w_disarm[i]) begin
        w_state_nxt[i] = ST_IDLE;
      end else if (w_arm[i]) begin
        if (r_load[i] != '0) begin
          w_count_nxt[i] = r_load[i];
          w_state_nxt[i] = ST_RUNNING;
        end else begin
          w_exp_set[i]   = 1'b1;
          w_state_nxt[i] = ST_IDLE;
        end
      end else if (r_state[i] == ST_RUNNING && w_tick) begin
        if (r_count[i] > CNT_W'(1)) begin
          w_count_nxt[i] = r_count[i] - CNT_W'(1);
        end else begin
          w_exp_set[i] = 1'b1;
          if (w_repeat[i] && r_load[i] != '0) begin
            w_count_nxt[i] = r_load[i];
          end else begin
            w_count_nxt[i] = '0;
            w_state_nxt[i] = ST_IDLE;
          end
        end
      end
    end
  end

  // Channel state, count and sticky expired flags; a same-cycle expiry beats W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_expired <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_count[i] <= '0;
      end
    end else begin
      r_expired <= (r_expired & ~w_w1c) | w_exp_set;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_count[i] <= w_count_nxt[i];
      end
    end
  end

  // Read mux over the register map; LOAD/COUNT of an absent channel read 0.
  always_comb begin
    w_sel_load  = '0;
    w_sel_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == 2'(i)) begin
        w_sel_load  = 16'(r_load[i]);
        w_sel_count = 16'(r_count[i]);
      end
    end
    case (address)
      3'd0:    w_rd_mux = 16'(r_expired);
      3'd1:    w_rd_mux = {r_run, 7'b0, w_repeat, r_irq_en};
      3'd2:    w_rd_mux = {14'b0, r_sel};
      3'd3:    w_rd_mux = w_sel_load;
      3'd4:    w_rd_mux = w_sel_count;
      3'd5:    w_rd_mux = 16'(w_active);
      3'd7:    w_rd_mux = 16'hA1A0;
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // Registered read data: one cycle of latency after the read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq      = |(r_expired & r_irq_en[NUM_CH-1:0]);

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: register table plus hand-timed countdown sequences
// for alarm_scheduler with TICK_DIV=4, NUM_CH=4.
module tb_alarm_scheduler;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int n_checks;
  int n_errors;

  logic [15:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

`ifdef ALARM_SCHED_REPEAT_EN
  localparam logic [15:0] CTRL_FF   = 16'h00FF;
  localparam logic [15:0] CTRL_8010 = 16'h8010;
`else
  localparam logic [15:0] CTRL_FF   = 16'h000F;
  localparam logic [15:0] CTRL_8010 = 16'h8000;
`endif

  alarm_scheduler #(.NUM_CH(4), .CNT_W(16), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checks and driver tasks
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic scoreboard_pop();
    logic [15:0] e;
    string nm;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: readdata %h with no expected value queued", readdata);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check16(nm, readdata, e);
    end
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    scoreboard_pop();
  endtask

  function automatic void add_vec(input logic wr, input logic [2:0] a, input logic [15:0] d,
                                  input logic [15:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check16("reset_readdata", readdata, 16'h0000);
    check16("reset_irq", {15'b0, irq}, 16'h0000);
    reset_n = 1'b1;
    idle(1);

    // Register table, run=0 so no ticks can intervene
    add_vec(0, 3'd7, 16'h0000, 16'hA1A0, "id");
    add_vec(0, 3'd0, 16'h0000, 16'h0000, "status_rst");
    add_vec(0, 3'd1, 16'h0000, 16'h0000, "control_rst");
    add_vec(0, 3'd6, 16'h0000, 16'h0000, "reg6");
    add_vec(1, 3'd1, 16'h00FF, 16'h0000, "");
    add_vec(0, 3'd1, 16'h0000, CTRL_FF,  "control_rb");
    add_vec(1, 3'd2, 16'h0003, 16'h0000, "");
    add_vec(0, 3'd2, 16'h0000, 16'h0003, "select_rb");
    add_vec(1, 3'd3, 16'h1234, 16'h0000, "");
    add_vec(0, 3'd3, 16'h0000, 16'h1234, "load_rb");
    add_vec(1, 3'd4, 16'h5555, 16'h0000, "");
    add_vec(0, 3'd4, 16'h0000, 16'h0000, "count_ro");
    add_vec(1, 3'd2, 16'h0000, 16'h0000, "");
    add_vec(0, 3'd3, 16'h0000, 16'h0000, "load0_rb");
    add_vec(1, 3'd5, 16'h0001, 16'h0000, "");
    add_vec(0, 3'd0, 16'h0000, 16'h0001, "arm_load0_expired");
    add_vec(0, 3'd5, 16'h0000, 16'h0000, "arm_load0_idle");
    add_vec(1, 3'd0, 16'h0001, 16'h0000, "");
    add_vec(0, 3'd0, 16'h0000, 16'h0000, "w1c_clear");
    add_vec(1, 3'd5, 16'h0101, 16'h0000, "");
    add_vec(0, 3'd0, 16'h0000, 16'h0000, "arm_disarm_same");
    add_vec(1, 3'd1, 16'h0000, 16'h0000, "");
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
      else           bus_read(tbl[i].a, tbl[i].exp, tbl[i].name);
    end

    // Basic countdown on channel 0; run write edge is E0, ticks at E4, E8, E12
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'h0003);
    bus_write(3'd1, 16'h8001);                 // E0
    bus_write(3'd5, 16'h0001);                 // E1: count=3
    bus_read(3'd4, 16'd3, "count_3");          // E2
    idle(3);                                   // E3..E5
    bus_read(3'd4, 16'd2, "count_2");          // E6
    idle(3);                                   // E7..E9
    bus_read(3'd4, 16'd1, "count_1");          // E10
    idle(1);                                   // E11
    check16("irq_before_expiry", {15'b0, irq}, 16'h0000);
    idle(1);                                   // E12: expiry
    check16("irq_at_expiry", {15'b0, irq}, 16'h0001);
    bus_read(3'd0, 16'h0001, "status_ch0");    // E13

    // W1C drops irq; then W1C in the exact expiry cycle of channel 3
    bus_write(3'd0, 16'h0001);
    check16("irq_after_w1c", {15'b0, irq}, 16'h0000);
    bus_write(3'd2, 16'h0003);
    bus_write(3'd3, 16'h0002);
    bus_write(3'd1, 16'h0000);
    bus_write(3'd1, 16'h8000);                 // E0
    bus_write(3'd5, 16'h0008);                 // E1: count=2
    idle(6);                                   // E2..E7
    bus_write(3'd0, 16'h0008);                 // E8: expiry with W1C
    bus_read(3'd0, 16'h0008, "expiry_beats_w1c");
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0, 16'h0000, "w1c_after_expiry");

    // Channels 1 and 2 armed, channel 2 disarmed after one tick
    bus_write(3'd1, 16'h0000);
    bus_write(3'd2, 16'h0001);
    bus_write(3'd3, 16'h0002);
    bus_write(3'd2, 16'h0002);
    bus_write(3'd3, 16'h0005);
    bus_write(3'd1, 16'h8000);                 // E0
    bus_write(3'd5, 16'h0006);                 // E1: counts 2,5
    idle(3);                                   // E2..E4: tick at E4
    bus_write(3'd5, 16'h0400);                 // E5
    bus_read(3'd5, 16'h0002, "active_after_disarm"); // E6
    idle(2);                                   // E7, E8: ch1 expires
    bus_read(3'd0, 16'h0002, "status_ch1_only");     // E9
    bus_read(3'd5, 16'h0000, "active_none");         // E10
    bus_read(3'd4, 16'd4, "ch2_frozen");             // E11
    idle(8);
    bus_read(3'd4, 16'd4, "ch2_still_frozen");
    bus_write(3'd0, 16'h0002);

    // Run cleared mid-countdown freezes count; restart ticks 4 cycles later
    bus_write(3'd1, 16'h0000);
    bus_write(3'd1, 16'h8000);                 // E0
    bus_write(3'd5, 16'h0004);                 // E1: count=5
    idle(3);                                   // tick at E4: count=4
    bus_write(3'd1, 16'h0000);                 // E5
    idle(20);
    bus_read(3'd4, 16'd4, "count_paused");
    bus_write(3'd1, 16'h8000);                 // S0
    idle(3);                                   // S1..S3
    bus_read(3'd4, 16'd4, "count_before_resume_tick"); // S4
    bus_read(3'd4, 16'd3, "count_after_resume_tick");  // S5

    // Reset mid-countdown aborts everything
    reset_n = 1'b0;
    #2;
    check16("reset_mid_readdata", readdata, 16'h0000);
    check16("reset_mid_irq", {15'b0, irq}, 16'h0000);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_write(3'd2, 16'h0002);
    bus_read(3'd4, 16'd0, "count_after_reset");
    bus_read(3'd5, 16'h0000, "active_after_reset");
    bus_read(3'd1, 16'h0000, "control_after_reset");

    // Repeat bit on channel 0 with load=2
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'h0002);
    bus_write(3'd1, 16'h8010);                 // E0
    bus_write(3'd5, 16'h0001);                 // E1
    bus_read(3'd1, CTRL_8010, "control_repeat_rb");  // E2
    idle(6);                                   // E3..E8: expiry at E8
    bus_read(3'd0, 16'h0001, "repeat_first_expiry"); // E9
`ifdef ALARM_SCHED_REPEAT_EN
    bus_write(3'd0, 16'h0001);                 // E10
    bus_read(3'd5, 16'h0001, "repeat_still_active"); // E11
    bus_read(3'd0, 16'h0000, "repeat_cleared");      // E12
    idle(4);                                   // E13..E16: second expiry
    bus_read(3'd0, 16'h0001, "repeat_second_expiry"); // E17
    bus_read(3'd5, 16'h0001, "repeat_active_again");  // E18
`else
    bus_read(3'd5, 16'h0000, "oneshot_idle");        // E10
    bus_read(3'd4, 16'd0, "oneshot_count_zero");     // E11
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
